// File: rtl/add_sub_shift_sequencer.sv
// Sequencer for the add/sub datapath's shared two-pass barrel shifter.
// It runs the alignment pass, then a normalization pass chosen from the adder's carry-out and leading-zero count.
module add_sub_shift_sequencer #(
    parameter int SWR = 26,
    parameter int EW  = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic [EW-1:0]  exp_diff_i,
    input  logic           add_valid_i,
    input  logic [SWR:0]   add_result_i,
    output logic [EW-1:0]  shift_value_0_o,
    output logic [EW-1:0]  shift_value_1_o,
    output logic           select_c_o,
    output logic           left_right_o,
    output logic           shifter_load_o,
    output logic [EW-1:0]  exp_adjust_o,
    output logic           exp_inc_o,
    output logic           zero_result_o,
    output logic           busy_o,
    output logic           done_o
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ALIGN    = 3'd1;
    localparam logic [2:0] ST_WAIT_ADD = 3'd2;
    localparam logic [2:0] ST_NORM     = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    localparam logic [EW-1:0] SWR_EW = EW'(SWR);

    logic [2:0]    state_reg, state_next;
    logic [EW-1:0] shift_value_0_reg, shift_value_0_next;
    logic [EW-1:0] shift_value_1_reg, shift_value_1_next;
    logic [EW-1:0] exp_adjust_reg, exp_adjust_next;
    logic          left_right_reg, left_right_next;
    logic          exp_inc_reg, exp_inc_next;
    logic          zero_result_reg, zero_result_next;

    // ------------------------------------------------------------------
    // Leading-zero count of the adder magnitude (carry bit excluded)
    // ------------------------------------------------------------------
    logic [SWR-1:0] mant;
    logic           carry;
    logic [SWR:0]   zero_above;          // zero_above[i]: bits [SWR-1:i] are all zero
    logic [SWR-1:0] lead_onehot;
    logic [EW-1:0]  lz_acc [0:SWR];
    logic [EW-1:0]  lz_count;
    logic           mant_zero;

    assign mant  = add_result_i[SWR-1:0];
    assign carry = add_result_i[SWR];

    assign zero_above[SWR] = 1'b1;
    assign lz_acc[SWR]     = '0;

    generate
        for (genvar gi = 0; gi < SWR; gi++) begin : g_lzc
            localparam logic [EW-1:0] LZ_VAL = EW'(SWR - 1 - gi);
            assign zero_above[gi]  = zero_above[gi+1] & ~mant[gi];
            assign lead_onehot[gi] = mant[gi] & zero_above[gi+1];
            assign lz_acc[gi]      = lz_acc[gi+1] | ({EW{lead_onehot[gi]}} & LZ_VAL);
        end
    endgenerate

    assign lz_count  = lz_acc[0];
    assign mant_zero = zero_above[0];

    // ------------------------------------------------------------------
    // Next-state and capture logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next         = state_reg;
        shift_value_0_next = shift_value_0_reg;
        shift_value_1_next = shift_value_1_reg;
        exp_adjust_next    = exp_adjust_reg;
        left_right_next    = left_right_reg;
        exp_inc_next       = exp_inc_reg;
        zero_result_next   = zero_result_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start_i) begin
                    shift_value_0_next = (exp_diff_i >= SWR_EW) ? SWR_EW : exp_diff_i;
                    shift_value_1_next = '0;
                    exp_adjust_next    = '0;
                    exp_inc_next       = 1'b0;
                    zero_result_next   = 1'b0;
                    // The alignment pass is always a right shift.
                    left_right_next    = 1'b0;
                    state_next         = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                state_next = ST_WAIT_ADD;
            end
            ST_WAIT_ADD: begin
                if (add_valid_i) begin
                    if (carry) begin
                        shift_value_1_next = EW'(1);
                        left_right_next    = 1'b0;
                        exp_inc_next       = 1'b1;
                        exp_adjust_next    = '0;
                        state_next         = ST_NORM;
                    end else if (mant_zero) begin
                        zero_result_next   = 1'b1;
                        exp_adjust_next    = SWR_EW;
                        shift_value_1_next = '0;
                        state_next         = ST_DONE;
                    end else begin
                        shift_value_1_next = lz_count;
                        left_right_next    = 1'b1;
                        exp_adjust_next    = lz_count;
                        state_next         = ST_NORM;
                    end
                end
            end
            ST_NORM: begin
                state_next = ST_DONE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= ST_IDLE;
            shift_value_0_reg <= '0;
            shift_value_1_reg <= '0;
            exp_adjust_reg    <= '0;
            left_right_reg    <= 1'b0;
            exp_inc_reg       <= 1'b0;
            zero_result_reg   <= 1'b0;
        end else begin
            state_reg         <= state_next;
            shift_value_0_reg <= shift_value_0_next;
            shift_value_1_reg <= shift_value_1_next;
            exp_adjust_reg    <= exp_adjust_next;
            left_right_reg    <= left_right_next;
            exp_inc_reg       <= exp_inc_next;
            zero_result_reg   <= zero_result_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registers only
    // ------------------------------------------------------------------
    assign shift_value_0_o = shift_value_0_reg;
    assign shift_value_1_o = shift_value_1_reg;
    assign exp_adjust_o    = exp_adjust_reg;
    assign exp_inc_o       = exp_inc_reg;
    assign zero_result_o   = zero_result_reg;
    assign left_right_o    = left_right_reg;
    assign shifter_load_o  = (state_reg == ST_ALIGN) || (state_reg == ST_NORM);
    assign select_c_o      = (state_reg == ST_NORM) || (state_reg == ST_DONE);
    assign busy_o          = (state_reg != ST_IDLE);
    assign done_o          = (state_reg == ST_DONE);

endmodule

// File: tb/tb_add_sub_shift_sequencer.sv
// Directed, table-driven bench for add_sub_shift_sequencer with hand-computed expectations.
// Outputs are sampled on the falling clock edge; inputs change there too.
module tb_add_sub_shift_sequencer;

    localparam int SWR = 26;
    localparam int EW  = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [EW-1:0]  exp_diff;
    logic           add_valid;
    logic [SWR:0]   add_result;
    logic [EW-1:0]  sv0, sv1, adj;
    logic           sel, lr, load, inc, zero, busy, done;

    add_sub_shift_sequencer #(.SWR(SWR), .EW(EW)) dut (
        .clk             (clk),
        .rst             (rst),
        .start_i         (start),
        .exp_diff_i      (exp_diff),
        .add_valid_i     (add_valid),
        .add_result_i    (add_result),
        .shift_value_0_o (sv0),
        .shift_value_1_o (sv1),
        .select_c_o      (sel),
        .left_right_o    (lr),
        .shifter_load_o  (load),
        .exp_adjust_o    (adj),
        .exp_inc_o       (inc),
        .zero_result_o   (zero),
        .busy_o          (busy),
        .done_o          (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [EW-1:0] diff;
        logic [SWR:0]  res;
        logic [EW-1:0] sv0;
        logic [EW-1:0] sv1;
        logic          lr;
        logic          inc;
        logic          zero;
        logic [EW-1:0] adj;
    } vec_t;

    vec_t vecs [7];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {8'd0, sv0, sv1, adj}, 32'd0);
        chk({name, "_flags"}, {25'd0, sel, lr, load, inc, zero, busy, done}, 32'd0);
    endtask

    // One full operation; stall = extra WAIT_ADD cycles, poke = inject start pulses while busy.
    task automatic op(input vec_t v, input int stall, input bit poke);
        @(negedge clk);
        start = 1'b1; exp_diff = v.diff;
        @(negedge clk);                       // ALIGN
        start = 1'b0;
        chk("align_load", load, 1);
        chk("align_sel", sel, 0);
        chk("align_lr", lr, 0);
        chk("align_sv0", sv0, v.sv0);
        chk("align_busy", busy, 1);
        chk("align_cleared", {sv1, adj, 6'd0, inc, zero}, 0);
        @(negedge clk);                       // WAIT_ADD
        for (int c = 0; c < stall; c++) begin
            chk("wait_busy", busy, 1);
            chk("wait_load", load, 0);
            chk("wait_done", done, 0);
            if (poke && c == 2) begin
                start = 1'b1; exp_diff = 8'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        chk("wait_load", load, 0);
        chk("wait_sel", sel, 0);
        add_valid = 1'b1; add_result = v.res;
        start = poke; exp_diff = poke ? 8'd3 : v.diff;
        @(negedge clk);
        add_valid = 1'b0; start = 1'b0;
        chk("cap_sv0", sv0, v.sv0);
        chk("cap_sv1", sv1, v.sv1);
        chk("cap_adj", adj, v.adj);
        chk("cap_inc", inc, v.inc);
        chk("cap_zero", zero, v.zero);
        chk("cap_sel", sel, 1);
        chk("cap_lr", lr, v.lr);
        if (v.zero) begin
            chk("zero_done", done, 1);
            chk("zero_noload", load, 0);
        end else begin
            chk("norm_load", load, 1);
            chk("norm_done", done, 0);
            @(negedge clk);
            chk("done_pulse", done, 1);
            chk("done_load", load, 0);
            chk("done_sel", sel, 1);
        end
        @(negedge clk);                       // back in IDLE
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_sel", sel, 0);
        chk("idle_load", load, 0);
        chk("hold_lr", lr, v.lr);
        chk("hold_vals", {sv0, sv1, adj, 6'd0, inc, zero}, {v.sv0, v.sv1, v.adj, 6'd0, v.inc, v.zero});
        $display("op diff=%0d res=0x%07h stall=%0d -> sv0=%0d sv1=%0d lr=%0b adj=%0d inc=%0b zero=%0b",
                 v.diff, v.res, stall, sv0, sv1, lr, adj, inc, zero);
    endtask

    initial begin
        vecs[0] = '{8'd5,   27'h0800000, 8'd5,  8'd2,  1'b1, 1'b0, 1'b0, 8'd2};
        vecs[1] = '{8'd40,  27'h4000001, 8'd26, 8'd1,  1'b0, 1'b1, 1'b0, 8'd0};
        vecs[2] = '{8'd26,  27'h0000000, 8'd26, 8'd0,  1'b0, 1'b0, 1'b1, 8'd26};
        vecs[3] = '{8'd25,  27'h2000000, 8'd25, 8'd0,  1'b1, 1'b0, 1'b0, 8'd0};
        vecs[4] = '{8'd0,   27'h0000001, 8'd0,  8'd25, 1'b1, 1'b0, 1'b0, 8'd25};
        vecs[5] = '{8'd255, 27'h0001234, 8'd26, 8'd13, 1'b1, 1'b0, 1'b0, 8'd13};
        vecs[6] = '{8'd1,   27'h4000000, 8'd1,  8'd1,  1'b0, 1'b1, 1'b0, 8'd0};

        rst = 1'b1; start = 1'b0; add_valid = 1'b0; exp_diff = '0; add_result = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        // add_valid while idle must be ignored
        add_valid = 1'b1; add_result = 27'h4000000;
        @(negedge clk);
        add_valid = 1'b0;
        chk("idle_addvalid_busy", busy, 0);
        chk("idle_addvalid_inc", inc, 0);
        @(negedge clk);
        chk("idle_addvalid_done", {load, done, sel}, 0);

        for (int i = 0; i < 7; i++) op(vecs[i], 0, 1'b0);

        // Stall with start pulses during busy, and start coinciding with add_valid
        op(vecs[0], 7, 1'b1);
        op(vecs[2], 4, 1'b1);

        // Reset while in WAIT_ADD
        @(negedge clk); start = 1'b1; exp_diff = 8'd9;
        @(negedge clk); start = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk_all_zero("rst_wait");

        // Reset while in NORM (left shift pending)
        @(negedge clk); start = 1'b1; exp_diff = 8'd7;
        @(negedge clk); start = 1'b0;
        @(negedge clk); add_valid = 1'b1; add_result = 27'h0100000;
        @(negedge clk); add_valid = 1'b0;
        chk("pre_rst_norm", {load, lr, sel}, 3'b111);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk_all_zero("rst_norm");
        @(negedge clk);
        chk("post_rst_idle", {busy, done}, 0);

        op(vecs[1], 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
